// File: rtl/hazard_pkg.sv
// Shared types and reset values for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01
    } state_t;

    localparam state_t RST_STATE   = RUN;
    localparam logic   RST_TIMEOUT = 1'b0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard-controller bus: pipeline status in (master drives), stage controls and counters out.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_destreg;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             memwb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_destreg,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
               ifid_flush, memwb_bubble, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_destreg,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
               ifid_flush, memwb_bubble, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count = cnt_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/freeze sequencing for the 5-stage pipeline, with performance
// counters and a sticky data-memory timeout flag.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  hz
);
    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    logic freeze, branch_act, load_use, stall_act;
    logic stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_comb begin
        freeze     = hz.mem_req & ~hz.mem_ready;
        load_use   = hz.ex_memread && (hz.ex_destreg != 5'd0) &&
                     ((hz.ex_destreg == hz.id_rs) ||
                      (hz.id_uses_rt && (hz.ex_destreg == hz.id_rt)));
        branch_act = ~freeze & hz.ex_branch_taken;
        // A taken branch squashes the ID instruction, so its load-use match is moot.
        stall_act  = ~freeze & ~hz.ex_branch_taken & load_use;
        stall_inc  = ~rst & (freeze | stall_act);
        flush_inc  = ~rst & branch_act;
    end

    always_comb begin
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.idex_write   = 1'b1;
        hz.exmem_write  = 1'b1;
        hz.idex_bubble  = 1'b0;
        hz.ifid_flush   = 1'b0;
        hz.memwb_bubble = 1'b0;
        if (rst) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
        end else if (freeze) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.exmem_write  = 1'b0;
            hz.memwb_bubble = 1'b1;
        end else if (branch_act) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (stall_act) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    // The wait count covers freeze cycles spent in MEM_WAIT; the entry cycle is in RUN.
    always_comb begin
        state_d    = freeze ? MEM_WAIT : RUN;
        wait_cnt_d = '0;
        if ((state_q == MEM_WAIT) && freeze)
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        timeout_d = timeout_q | (wait_cnt_d == WAIT_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            wait_cnt_q <= '0;
            timeout_q  <= RST_TIMEOUT;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign hz.mem_timeout  = timeout_q;
    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_count  = flush_cnt;
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS core. It sequences stalls, bubbles, flushes and freezes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers for three cases: load-use hazards the forwarding path cannot cover, taken branches resolved in EX, and multi-cycle data-memory accesses. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
- MAX_WAIT, 64: memory-wait cycles allowed before the timeout flag is raised.
- CNT_W, 16: performance counter width.

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_memread  in  1  ID/EX holds a load.
- ex_destreg  in  5  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  EX/MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register write enables.
- idex_bubble  out  1  load NOP control into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- memwb_bubble  out  1  load NOP into MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cycles, flush_count  out  CNT_W each  saturating counters.

## Operation
- States: RUN, MEM_WAIT (2-bit encoded). Outputs are combinational from the state and current inputs. State, counters and the flag update on the rising clk edge.
- Event priority: mem freeze > branch flush > load-use stall.
- Mem freeze condition: mem_req & !mem_ready, valid in either state.
  - pc_write, ifid_write, idex_write and exmem_write are all 0.
  - memwb_bubble is 1.
  - ifid_flush and idex_bubble are 0.
  - Next state is MEM_WAIT.
- In MEM_WAIT with mem_ready=1: the state returns to RUN, and the outputs for that cycle follow the RUN rules below.
- Branch flush (no freeze, ex_branch_taken=1):
  - ifid_flush=1 and idex_bubble=1.
  - pc_write=1, so the target is loaded.
  - All other write enables are 1.
  - A load-use match in the same cycle is ignored because that instruction is squashed.
- Load-use stall condition: ex_memread & ex_destreg≠0 & (ex_destreg==id_rs | (id_uses_rt & ex_destreg==id_rt)).
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - exmem_write=1 and idex_write=1.
- Default: all write enables 1; all bubble and flush outputs 0.
- Counters:
  - stall_cycles increments for each freeze cycle and each load-use stall cycle.
  - flush_count increments for each branch flush cycle.
  - Both saturate at all-ones and never wrap.
- Wait counter: counts consecutive MEM_WAIT cycles.
  - mem_timeout sets when the counter reaches MAX_WAIT.
  - The flag stays set until rst. The freeze continues while it is set.
  - The counter clears on leaving MEM_WAIT.

## Timing
- Stall, flush and freeze decisions take effect in the same cycle as their inputs (zero latency). Pipeline registers sample the enables at the next edge.
- A load-use stall lasts exactly 1 cycle, because the bubble removes the match.
- A freeze lasts until mem_ready is seen. With mem_ready at cycle N, the pipeline advances at edge N+1.
- If a branch is taken during a freeze, the EX stage is held, so ex_branch_taken stays asserted. The flush is applied in the cycle mem_ready arrives.
- Reset values (async, immediate):
  - State RUN.
  - Counters and wait counter 0; mem_timeout 0.
  - While rst is high, all write enables are 0 and all bubble/flush outputs are 0.
- Reset mid-MEM_WAIT aborts the wait. No flush is issued afterward.

## Structure
- Package hazard_pkg holds the state enum (RUN, MEM_WAIT) and the reset-value constants.
- One sub-module, sat_counter (parameterized width, inc, clk/rst), is instantiated twice for the performance counters.
- The wait counter and FSM stay inline.

## Test plan
- ex_memread=1, ex_destreg=5, id_rs=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles 0→1; normal operation next cycle.
- Same as above with ex_destreg=0, or id_rt=5 with id_uses_rt=0 -> no stall.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_count=1; stall_cycles unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles (all write enables 0, memwb_bubble=1); stall_cycles=3; RUN restored after the mem_ready cycle.
- MAX_WAIT=4 with mem_ready held low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready; clears only on rst.
- Assert rst while in MEM_WAIT -> outputs go to reset values immediately; after release, state is RUN and counters are 0.
- Force 2^CNT_W+2 stall cycles -> stall_cycles holds at all-ones.
